// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the register-rename (RR) stage.
//   RR_C_NUM  : number of RAT checkpoint slots (power of two, >= 2)
//   RR_CID_W  : checkpoint ID width
//   RR_CNT_W  : occupancy counter width (must be able to hold RR_C_NUM)
//   predictor_update_t : back-end branch resolution record; the rename
//                        wrapper maps valid_jump/rat_id onto the checkpoint
//                        controller's resolve ports.
// ---------------------------------------------------------------------------
package rr_pkg;

  localparam int RR_C_NUM = 4;
  localparam int RR_CID_W = $clog2(RR_C_NUM);
  localparam int RR_CNT_W = $clog2(RR_C_NUM + 1);

  // A correctly predicted branch resolving, tagged with its RAT checkpoint
  typedef struct packed {
    logic                valid_jump;
    logic [RR_CID_W-1:0] rat_id;
  } predictor_update_t;

endpackage

// File: rtl/rat_ckpt_age_mask.sv
// ---------------------------------------------------------------------------
// rat_ckpt_age_mask
// Combinational age comparator for the circular checkpoint queue.
// Marks every slot that is at the same age as id_i or younger, bounded by
// the allocation pointer.
//   head_i : oldest live slot
//   tail_i : next slot to be allocated
//   id_i   : reference checkpoint ID
//   mask_o : bit i set when slot i lies in [id_i, tail_i) in queue order
// When head_i == tail_i the queue is either full or empty. Because callers
// always combine the mask with per-slot valid bits, treating that case as
// "full" is safe.
// ---------------------------------------------------------------------------
module rat_ckpt_age_mask
  import rr_pkg::*;
#(
  parameter int C_NUM = RR_C_NUM,
  parameter int CID_W = $clog2(C_NUM)
) (
  input  logic [CID_W-1:0] head_i,
  input  logic [CID_W-1:0] tail_i,
  input  logic [CID_W-1:0] id_i,
  output logic [C_NUM-1:0] mask_o
);

  logic [CID_W-1:0] id_off;
  logic [CID_W-1:0] tail_off;
  logic [CID_W-1:0] slot_off;

  // Compare distances from the head instead of raw IDs. This keeps the
  // ordering correct across the wrap point of the ring.
  always_comb begin
    id_off   = id_i - head_i;
    tail_off = tail_i - head_i;
    slot_off = '0;
    mask_o   = '0;
    for (int i = 0; i < C_NUM; i++) begin
      slot_off  = CID_W'(i) - head_i;
      mask_o[i] = (slot_off >= id_off) &&
                  ((slot_off < tail_off) || (tail_off == '0));
    end
  end

endmodule

// File: rtl/rat_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// rat_checkpoint_ctrl
// Hands out RAT checkpoint IDs to renamed branches, at most two per cycle.
// The slots form a circular queue. A slot retires in order from the head
// once its branch has resolved correctly. A mispredict flush restores the
// named snapshot and drops it together with every younger slot.
//
// Ports
//   clk, rst               : clock, async active-high reset
//   alloc_req_1_i/_2_i     : rename port 1/2 carries a branch
//   alloc_en_i             : rename handshake fires this cycle
//   alloc_ready_o          : enough free slots for the current request
//   alloc_id_1_o/_2_o      : checkpoint IDs offered to port 1/2
//   resolve_valid_i/id_i   : branch resolved correctly, frees its slot
//   flush_valid_i/rat_id_i : mispredict, restore this checkpoint
//   restore_valid_o/id_o   : one-cycle registered restore command to RAT
//   free_cnt_o             : free slot count
// ---------------------------------------------------------------------------
module rat_checkpoint_ctrl
  import rr_pkg::*;
#(
  parameter int C_NUM = RR_C_NUM,
  parameter int CID_W = $clog2(C_NUM),
  parameter int CNT_W = $clog2(C_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req_1_i,
  input  logic             alloc_req_2_i,
  input  logic             alloc_en_i,
  output logic             alloc_ready_o,
  output logic [CID_W-1:0] alloc_id_1_o,
  output logic [CID_W-1:0] alloc_id_2_o,
  input  logic             resolve_valid_i,
  input  logic [CID_W-1:0] resolve_id_i,
  input  logic             flush_valid_i,
  input  logic [CID_W-1:0] flush_rat_id_i,
  output logic             restore_valid_o,
  output logic [CID_W-1:0] restore_id_o,
  output logic [CNT_W-1:0] free_cnt_o
);

  logic [CID_W-1:0] head_q, head_d;
  logic [CID_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [C_NUM-1:0] valid_q, valid_d;
  logic [C_NUM-1:0] resolved_q, resolved_d;
  logic             restore_valid_q, restore_valid_d;
  logic [CID_W-1:0] restore_id_q, restore_id_d;

  logic [1:0]       req_n;
  logic [CNT_W-1:0] free_slots;
  logic             alloc_fire;
  logic             flush_hit;
  logic             retire;
  logic             resolve_hit;
  logic [C_NUM-1:0] flush_mask;

  // Slots at or younger than the flush target. The same mask invalidates
  // them and filters out a resolve that targets a slot being discarded.
  rat_ckpt_age_mask #(
    .C_NUM (C_NUM),
    .CID_W (CID_W)
  ) u_age_mask (
    .head_i (head_q),
    .tail_i (tail_q),
    .id_i   (flush_rat_id_i),
    .mask_o (flush_mask)
  );

  // Allocation is decided combinationally from registered occupancy. A slot
  // retiring this cycle cannot be reused until the next cycle.
  assign req_n         = {1'b0, alloc_req_1_i} + {1'b0, alloc_req_2_i};
  assign free_slots    = CNT_W'(C_NUM) - cnt_q;
  assign alloc_ready_o = !flush_valid_i && (free_slots >= CNT_W'(req_n));
  assign alloc_id_1_o  = tail_q;
  assign alloc_id_2_o  = alloc_req_1_i ? (tail_q + CID_W'(1)) : tail_q;
  assign alloc_fire    = alloc_en_i && alloc_ready_o && (req_n != 2'd0);

  // A flush only counts when it names a live checkpoint.
  assign flush_hit = flush_valid_i && valid_q[flush_rat_id_i];

  // The head is never the flushed slot when it retires alongside a flush,
  // so it is strictly older and retires normally.
  assign retire = (cnt_q != '0) && valid_q[head_q] && resolved_q[head_q] &&
                  !(flush_hit && (head_q == flush_rat_id_i));

  assign resolve_hit = resolve_valid_i && valid_q[resolve_id_i] &&
                       !(flush_hit && flush_mask[resolve_id_i]);

  assign restore_valid_o = restore_valid_q;
  assign restore_id_o    = restore_id_q;
  assign free_cnt_o      = free_slots;

  // Next-state logic. Updates are applied in this order: resolve, retire,
  // then either flush or allocate. The flush recomputes occupancy from the
  // post-retire head, so a same-cycle retire is already reflected.
  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    cnt_d           = cnt_q;
    valid_d         = valid_q;
    resolved_d      = resolved_q;
    restore_valid_d = flush_hit;
    restore_id_d    = flush_hit ? flush_rat_id_i : restore_id_q;

    if (resolve_hit) begin
      resolved_d[resolve_id_i] = 1'b1;
    end

    if (retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + CID_W'(1);
    end

    if (flush_hit) begin
      valid_d    = valid_d & ~flush_mask;
      resolved_d = resolved_d & ~flush_mask;
      tail_d     = flush_rat_id_i;
      cnt_d      = CNT_W'(CID_W'(flush_rat_id_i - head_d));
    end else begin
      if (alloc_fire) begin
        if (alloc_req_1_i) begin
          valid_d[alloc_id_1_o]    = 1'b1;
          resolved_d[alloc_id_1_o] = 1'b0;
        end
        if (alloc_req_2_i) begin
          valid_d[alloc_id_2_o]    = 1'b1;
          resolved_d[alloc_id_2_o] = 1'b0;
        end
        tail_d = tail_q + CID_W'(req_n);
      end
      cnt_d = cnt_q + (alloc_fire ? CNT_W'(req_n) : '0)
                    - (retire ? CNT_W'(1) : '0);
    end
  end

  // State registers. Reset drops any restore that is still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      cnt_q           <= '0;
      valid_q         <= '0;
      resolved_q      <= '0;
      restore_valid_q <= 1'b0;
      restore_id_q    <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      cnt_q           <= cnt_d;
      valid_q         <= valid_d;
      resolved_q      <= resolved_d;
      restore_valid_q <= restore_valid_d;
      restore_id_q    <= restore_id_d;
    end
  end

endmodule

// File: tb/tb_rat_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rat_checkpoint_ctrl
// Directed scoreboard bench for rat_checkpoint_ctrl with C_NUM = 4.
// The stimulus process queues hand-computed expectations, each tagged with
// the cycle in which it must hold. A negedge monitor pops and compares them.
// Restore pulses are matched against a separate queue of expected IDs.
// ---------------------------------------------------------------------------
module tb_rat_checkpoint_ctrl;

  localparam int C_NUM = 4;
  localparam int CID_W = 2;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_req_1 = 1'b0;
  logic             alloc_req_2 = 1'b0;
  logic             alloc_en = 1'b0;
  logic             alloc_ready;
  logic [CID_W-1:0] alloc_id_1;
  logic [CID_W-1:0] alloc_id_2;
  logic             resolve_valid = 1'b0;
  logic [CID_W-1:0] resolve_id = '0;
  logic             flush_valid = 1'b0;
  logic [CID_W-1:0] flush_rat_id = '0;
  logic             restore_valid;
  logic [CID_W-1:0] restore_id;
  logic [CNT_W-1:0] free_cnt;

  rat_checkpoint_ctrl #(
    .C_NUM (C_NUM),
    .CID_W (CID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req_1_i   (alloc_req_1),
    .alloc_req_2_i   (alloc_req_2),
    .alloc_en_i      (alloc_en),
    .alloc_ready_o   (alloc_ready),
    .alloc_id_1_o    (alloc_id_1),
    .alloc_id_2_o    (alloc_id_2),
    .resolve_valid_i (resolve_valid),
    .resolve_id_i    (resolve_id),
    .flush_valid_i   (flush_valid),
    .flush_rat_id_i  (flush_rat_id),
    .restore_valid_o (restore_valid),
    .restore_id_o    (restore_id),
    .free_cnt_o      (free_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index. Stimulus changes at posedge+1 and checks run at the
  // following negedge, both using the same value.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_READY, K_ID1, K_ID2, K_FREE, K_RVALID} kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
    string name;
  } exp_t;

  exp_t expQ[$];
  int   rstQ[$];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic expectOutput(input int dly, input kind_e k, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    expQ.push_back(e);
  endtask

  function automatic int sampleKind(input kind_e k);
    case (k)
      K_READY:  return int'(alloc_ready);
      K_ID1:    return int'(alloc_id_1);
      K_ID2:    return int'(alloc_id_2);
      K_FREE:   return int'(free_cnt);
      K_RVALID: return int'(restore_valid);
      default:  return -1;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, and match any
  // restore pulse against the next expected restore ID.
  always @(negedge clk) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cyc) begin
        checkOutput(expQ[i].name, sampleKind(expQ[i].kind), expQ[i].val);
        expQ.delete(i);
      end
    end
    if (restore_valid) begin
      if (rstQ.size() == 0) checkOutput("unexpected_restore", 1, 0);
      else checkOutput("restore_id", int'(restore_id), rstQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic r1, input logic r2, input logic en,
                               input logic rv, input int rid,
                               input logic fv, input int fid);
    @(posedge clk);
    #1;
    alloc_req_1   = r1;
    alloc_req_2   = r2;
    alloc_en      = en;
    resolve_valid = rv;
    resolve_id    = rid[CID_W-1:0];
    flush_valid   = fv;
    flush_rat_id  = fid[CID_W-1:0];
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // Fill all four slots with two dual allocations: IDs 0,1 then 2,3
  task automatic fillAll();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(1, K_FREE, 0, "fill_free");
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    alloc_req_1   = 1'b0;
    alloc_req_2   = 1'b0;
    alloc_en      = 1'b0;
    resolve_valid = 1'b0;
    flush_valid   = 1'b0;
    expectOutput(0, K_RVALID, 0, "reset_rvalid");
    expectOutput(0, K_FREE, 4, "reset_free");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and dual allocations
    idle();
    expectOutput(0, K_FREE, 4, "rst_free");
    expectOutput(0, K_READY, 1, "rst_ready");
    expectOutput(0, K_RVALID, 0, "rst_rvalid");
    expectOutput(0, K_ID1, 0, "rst_id1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 1, "dual1_ready");
    expectOutput(0, K_ID1, 0, "dual1_id1");
    expectOutput(0, K_ID2, 1, "dual1_id2");
    expectOutput(1, K_FREE, 2, "dual1_free");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 1, "dual2_ready");
    expectOutput(0, K_ID1, 2, "dual2_id1");
    expectOutput(0, K_ID2, 3, "dual2_id2");
    expectOutput(1, K_FREE, 0, "dual2_free");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 0, "full_ready");

    // Resolve head while full, then wrap-around single allocation
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
    expectOutput(0, K_FREE, 0, "resolve0_free");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 0, "full_retire_ready");
    expectOutput(1, K_FREE, 1, "retire0_free");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 0, "dual_stall_ready");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 1, "wrap_ready");
    expectOutput(0, K_ID1, 0, "wrap_id1");
    expectOutput(1, K_FREE, 0, "wrap_free");
    idle();
    doReset();

    // Out-of-order resolve: retire only proceeds in order
    fillAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
    expectOutput(0, K_FREE, 0, "ooo_hold_free");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0);
    expectOutput(0, K_FREE, 0, "ooo_pre_free");
    idle();
    expectOutput(0, K_FREE, 1, "ooo_ret0_free");
    idle();
    expectOutput(0, K_FREE, 2, "ooo_ret1_free");
    idle();
    expectOutput(0, K_FREE, 3, "ooo_ret2_free");
    idle();
    expectOutput(0, K_FREE, 3, "ooo_slot3_held");
    doReset();

    // Flush of checkpoint 1 with all slots live
    fillAll();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1);
    expectOutput(0, K_READY, 0, "flush_no_alloc");
    rstQ.push_back(1);
    expectOutput(1, K_FREE, 3, "flush1_free");
    expectOutput(1, K_ID1, 1, "flush1_tail");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 1, "post_flush_ready");
    expectOutput(1, K_FREE, 2, "post_flush_free");
    expectOutput(1, K_RVALID, 0, "restore_one_cycle");
    idle();
    doReset();

    // Flush of the head with head=2, tail=0
    fillAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2);
    expectOutput(0, K_FREE, 2, "head2_free");
    rstQ.push_back(2);
    expectOutput(1, K_FREE, 4, "headflush_free");
    expectOutput(1, K_ID1, 2, "headflush_id1");
    expectOutput(1, K_READY, 1, "headflush_ready");
    idle();
    doReset();

    // Flush 3 + resolve 3 + request in one cycle, then older-resolve and
    // head-retire interactions with flush
    fillAll();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1, 3);
    expectOutput(0, K_READY, 0, "combo_ready");
    rstQ.push_back(3);
    expectOutput(1, K_FREE, 1, "combo_free");
    expectOutput(1, K_ID1, 3, "combo_tail");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_READY, 1, "refill_ready");
    expectOutput(1, K_FREE, 0, "refill_free");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 2);
    rstQ.push_back(2);
    expectOutput(1, K_FREE, 2, "older_resolve_free");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1);
    rstQ.push_back(1);
    expectOutput(1, K_FREE, 4, "retire_flush_free");
    expectOutput(1, K_ID1, 1, "retire_flush_tail");
    idle();
    idle();
    expectOutput(0, K_RVALID, 0, "retire_flush_rvalid");
    doReset();

    // Flush on an invalid slot is ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    expectOutput(0, K_ID1, 0, "single_id1");
    expectOutput(1, K_FREE, 3, "single_free");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2);
    expectOutput(1, K_RVALID, 0, "bad_flush_rvalid");
    expectOutput(1, K_FREE, 3, "bad_flush_free");
    expectOutput(1, K_ID1, 1, "bad_flush_tail");
    idle();

    // Reset while a restore is about to be presented
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
    doReset();
    idle();
    idle();

    checkOutput("expq_drained", expQ.size(), 0);
    checkOutput("restoreq_drained", rstQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rat_checkpoint_ctrl.md
Name: rat_checkpoint_ctrl

Overview:
- Manages the C_NUM RAT checkpoint slots used by the rename stage. Allocates a checkpoint ID to each renamed branch, up to 2 per cycle.
- Checkpoints are released when the branch resolves correctly. On a mispredict flush, the RAT is told to restore the flushed checkpoint, which is freed together with all younger checkpoints.
- Sits beside the RAT in the RR stage, between decode and issue. It takes flush and predictor-update inputs from the back end.

Parameters:
- C_NUM, 4, number of RAT checkpoint slots (power of 2, at least 2).
- CID_W, $clog2(C_NUM), checkpoint ID width.
- CNT_W, $clog2(C_NUM+1), occupancy counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req_1_i  in  1  port-1 instruction is a valid branch needing a checkpoint.
- alloc_req_2_i  in  1  port-2 instruction is a valid branch needing a checkpoint.
- alloc_en_i  in  1  rename handshake fires this cycle (valid & ready downstream).
- alloc_ready_o  out  1  enough free slots for the current requests; rename stalls when low.
- alloc_id_1_o  out  CID_W  checkpoint ID for port 1.
- alloc_id_2_o  out  CID_W  checkpoint ID for port 2.
- resolve_valid_i  in  1  correctly-predicted branch resolved (pr_update.valid_jump, no flush).
- resolve_id_i  in  CID_W  rat_id of that branch.
- flush_valid_i  in  1  mispredict flush.
- flush_rat_id_i  in  CID_W  checkpoint to restore.
- restore_valid_o  out  1  registered pulse: RAT restores snapshot.
- restore_id_o  out  CID_W  snapshot to restore.
- free_cnt_o  out  CNT_W  free slots.

Behaviour:
- State:
  - Circular queue with head (oldest) and tail (next alloc), both CID_W.
  - cnt (occupied slots), CNT_W.
  - Per-slot valid[] and resolved[].
- Reset (async):
  - head = tail = 0, cnt = 0, valid[] = 0, resolved[] = 0.
  - restore_valid_o = 0, restore_id_o = 0.
  - free_cnt_o = C_NUM.
  - alloc_ready_o = 1 when no request is pending.
- Allocation is combinational on the current state:
  - req_n = alloc_req_1_i + alloc_req_2_i.
  - alloc_ready_o = !flush_valid_i && (C_NUM - cnt >= req_n).
  - Allocation is all-or-nothing: both branches or neither.
  - alloc_id_1_o = tail.
  - alloc_id_2_o = tail+1 if alloc_req_1_i, else tail. All arithmetic is mod C_NUM (natural CID_W wrap).
  - Commit when alloc_en_i && alloc_ready_o: set valid for each granted slot, clear resolved, tail += req_n.
- Resolve:
  - resolve_valid_i on a valid slot sets resolved[resolve_id_i].
  - Resolve on an invalid slot is ignored.
- Retire:
  - Each cycle, if cnt > 0 and valid[head] && resolved[head], clear the slot and head++.
  - At most 1 slot retires per cycle.
  - Same-cycle resolve of head does not retire until the next cycle.
- Flush, when flush_valid_i and valid[flush_rat_id_i]:
  - Next cycle: restore_valid_o = 1 and restore_id_o = flush_rat_id_i, held for 1 cycle.
  - Slots from flush_rat_id_i through tail-1 are invalidated.
  - tail = flush_rat_id_i; cnt = (flush_rat_id_i - head) mod C_NUM.
  - If flush_rat_id_i == head, cnt = 0 even though head == tail.
  - No allocation in the flush cycle.
- Flush on an invalid slot is ignored: no restore, no state change.
- Simultaneous events in a flush cycle:
  - Resolve of a slot younger than or equal to the flush ID is dropped.
  - Resolve of an older slot applies.
  - Head retire proceeds only if head != flush_rat_id_i. Since the head is older, it retires normally and head advances; cnt is computed from the updated head.
- Counter: cnt_next = cnt + allocs - retire, with flush overriding. cnt never exceeds C_NUM or goes below 0.
- Full (cnt == C_NUM):
  - Any request drops alloc_ready_o.
  - A retire in the same cycle does not grant; the grant comes the next cycle.
- free_cnt_o = C_NUM - cnt, registered state.
- Reset mid-operation clears everything immediately; any pending restore is lost.

Decomposition:
- rr_pkg (shared):
  - C_NUM and CID_W constants.
  - predictor_update typedef; the wrapper maps valid_jump and rat_id onto the resolve ports.
- One natural sub-module: rat_ckpt_age_mask.
  - Combinational.
  - Given head, tail and an ID, it outputs the C_NUM-bit mask of slots "at or younger than ID".
  - Used for both flush invalidation and resolve filtering.

Test Plan:
- Reset, then alloc_req_1=1 and alloc_req_2=1 with alloc_en=1 for two cycles:
  - IDs (0,1), then (2,3).
  - free_cnt goes 4, then 2, then 0.
  - A third request sees alloc_ready_o=0.
- Full, resolve id 0: the next cycle retires slot 0 (free_cnt=1). A dual request stays stalled; a single request gets ID 0 (wrap).
- Slots 0–3 live, resolve id 2 before ids 0 and 1: no retire until 0 and 1 resolve. Then 0, 1 and 2 retire on 3 consecutive cycles.
- Slots 0–3 live, flush_rat_id=1:
  - Next cycle restore_valid_o=1 and restore_id_o=1.
  - tail=1 and free_cnt=3.
  - Next allocation gets ID 1.
- Flush of head id with head=2 and tail=0 (slots 2, 3 live): cnt=0, free_cnt=4, and alloc_id_1_o=2.
- Single-cycle edge cases:
  - Flush id 3, resolve id 3, and a request all in one cycle: no grant, resolve dropped, restore id 3.
  - Flush on an invalid id: no restore_valid_o.
  - rst asserted mid-flush: restore_valid_o=0 immediately.
